// File: rtl/button_operand_entry.sv
// Button operand entry: conditions four raw pushbuttons (synchronize,
// debounce, rising-edge pulse) and uses the press pulses to build two
// operands that are handed to the adder datapath with a valid/ready handshake.
module button_operand_entry #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter int OPERAND_WIDTH   = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [3:0]               i_buttons,
  input  logic                     i_out_ready,
  output logic [OPERAND_WIDTH-1:0] o_operand_a,
  output logic [OPERAND_WIDTH-1:0] o_operand_b,
  output logic                     o_out_valid,
  output logic [1:0]               o_state_leds,
  output logic [3:0]               o_btn_pulse
);

  // Counter only has to reach DEBOUNCE_CYCLES-1
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ENTER_A = 2'b00,
    ST_ENTER_B = 2'b01,
    ST_PRESENT = 2'b10
  } state_t;

  logic [3:0] w_pulse;

  // Per-button conditioning chain
  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_stable;
    logic                   r_stable_d;
    logic                   r_pulse;
    logic                   w_level;

    assign w_level = r_sync[SYNC_STAGES-1];

    // Shift the raw button through the synchronizer flops
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], i_buttons[gi]};
      end
    end

    // Accept a level change only after it has been seen DEBOUNCE_CYCLES times in a row
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_cnt    <= '0;
        r_stable <= 1'b0;
      end else if (w_level == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt    <= '0;
        r_stable <= w_level;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    // One-cycle pulse on the debounced press (release is ignored)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_stable_d <= 1'b0;
        r_pulse    <= 1'b0;
      end else begin
        r_stable_d <= r_stable;
        r_pulse    <= r_stable & ~r_stable_d;
      end
    end

    assign w_pulse[gi] = r_pulse;
  end

  state_t                   r_state;
  logic [OPERAND_WIDTH-1:0] r_operand_a;
  logic [OPERAND_WIDTH-1:0] r_operand_b;
  logic                     r_out_valid;
  logic                     w_inc;
  logic                     w_dec;

  // Increment and decrement in the same cycle cancel out
  assign w_inc = w_pulse[0] & ~w_pulse[1];
  assign w_dec = w_pulse[1] & ~w_pulse[0];

  // Entry FSM: clear beats advance, advance beats inc/dec, PRESENT waits for the handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_ENTER_A;
      r_operand_a <= '0;
      r_operand_b <= '0;
      r_out_valid <= 1'b0;
    end else if (w_pulse[3]) begin
      r_state     <= ST_ENTER_A;
      r_operand_a <= '0;
      r_operand_b <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_ENTER_A: begin
          if (w_pulse[2]) begin
            r_state <= ST_ENTER_B;
          end else if (w_inc) begin
            r_operand_a <= r_operand_a + OPERAND_WIDTH'(1);
          end else if (w_dec) begin
            r_operand_a <= r_operand_a - OPERAND_WIDTH'(1);
          end
        end
        ST_ENTER_B: begin
          if (w_pulse[2]) begin
            r_state     <= ST_PRESENT;
            r_out_valid <= 1'b1;
          end else if (w_inc) begin
            r_operand_b <= r_operand_b + OPERAND_WIDTH'(1);
          end else if (w_dec) begin
            r_operand_b <= r_operand_b - OPERAND_WIDTH'(1);
          end
        end
        ST_PRESENT: begin
          // Operands are left as they are so the next entry starts from them
          if (i_out_ready) begin
            r_state     <= ST_ENTER_A;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_ENTER_A;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_operand_a  = r_operand_a;
  assign o_operand_b  = r_operand_b;
  assign o_out_valid  = r_out_valid;
  assign o_state_leds = r_state;
  assign o_btn_pulse  = w_pulse;

endmodule
